mem_port_arbiter: RTL and testbench

- Shares one external memory port between the fetch stage and the execute load/store path.
- Fetch issues instruction reads; execute issues data reads and byte-strobed writes.
- The block arbitrates, latches the winning request, and drives a req/ack memory handshake with one transaction in flight.
- It returns the response to the owner and guards the port with a starvation limit and an ack timeout.

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between the fetch stage and the execute
//   load/store path. In IDLE it grants one requester: data wins by default,
//   and fetch wins once data has taken MAX_DATA_STREAK consecutive grants
//   while fetch was waiting. It latches the winning request and holds
//   mem_req until mem_ack arrives or the ack timeout expires. The response
//   then goes back to the owner as a registered one-cycle rvalid pulse.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt        fetch request and its grant
//   if_rvalid/if_rdata/if_err       fetch response (err = timed out)
//   d_req/d_we/d_addr/d_wdata       data request (d_we == 0 means read)
//   d_gnt                           data grant
//   d_rvalid/d_rdata/d_err          data response (rdata is 0 for writes)
//   mem_req/mem_addr/mem_we/
//   mem_wdata, mem_ack/mem_rdata    external memory handshake
//   busy                            an access is in flight
module mem_port_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int MEM_TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int TW = $clog2(MEM_TIMEOUT);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state, state_next;
    logic            owner_data;   // 1: the access in flight belongs to execute
    logic [SW-1:0]   streak;
    logic [TW-1:0]   tmo_cnt;
    logic            done;
    logic            timed_out;

    always_comb begin
        state_next = state;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        done       = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (if_req && (!d_req || streak == SW'(MAX_DATA_STREAK))) begin
                    if_gnt     = 1'b1;
                    state_next = ACCESS;
                end else if (d_req) begin
                    d_gnt      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // An ack in the final timeout cycle still counts as success.
                timed_out = (tmo_cnt == TW'(MEM_TIMEOUT - 1));
                if (mem_ack || timed_out) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner_data <= 1'b0;
            streak     <= '0;
            tmo_cnt    <= '0;
            mem_addr   <= '0;
            mem_we     <= '0;
            mem_wdata  <= '0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            if_err     <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
        end else begin
            state     <= state_next;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;

            if (if_gnt) begin
                owner_data <= 1'b0;
                mem_addr   <= if_addr;
                mem_we     <= '0;
                mem_wdata  <= '0;
                streak     <= '0;
                tmo_cnt    <= '0;
            end

            if (d_gnt) begin
                owner_data <= 1'b1;
                mem_addr   <= d_addr;
                mem_we     <= d_we;
                mem_wdata  <= d_wdata;
                tmo_cnt    <= '0;
                // Only a grant that made fetch wait extends the streak.
                if (if_req) begin
                    if (streak != SW'(MAX_DATA_STREAK))
                        streak <= streak + 1'b1;
                end else begin
                    streak <= '0;
                end
            end

            if (state == ACCESS && !done)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (done) begin
                if (owner_data) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= (mem_ack && mem_we == 4'b0000) ? mem_rdata : '0;
                    d_err    <= !mem_ack;
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= mem_ack ? mem_rdata : '0;
                    if_err    <= !mem_ack;
                end
            end
        end
    end

    assign mem_req = (state == ACCESS);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with MAX_DATA_STREAK=4 and
//   MEM_TIMEOUT=8. Each table record is one clock cycle: the inputs driven
//   in that cycle and the outputs expected before the next rising edge.
//   Inputs change on the falling edge and outputs are sampled 1 time unit
//   later. Multi-cycle corner cases are written out by hand after the
//   table.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_we;
    logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_we;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_DATA_STREAK(4), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        dr;
        logic [3:0]  dwe;
        logic [31:0] da, dwd;
        logic        ack;
        logic [31:0] mrd;
        logic        e_ifg, e_dg, e_mreq, e_ifv, e_dv;
        logic [31:0] e_rd;     // rdata of whichever rvalid is expected
        logic        e_err;
        logic [31:0] e_maddr;
        logic [3:0]  e_mwe;
        logic [31:0] e_mwd;
    } vec_t;

    vec_t        vq[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    string       tag;

    // Table-builder state: current inputs and the expected latched request.
    logic        b_ifr = 0, b_dr = 0, b_ack = 0;
    logic [31:0] b_ifa = 0, b_da = 0, b_dwd = 0, b_mrd = 0;
    logic [3:0]  b_dwe = 0;
    logic [31:0] x_maddr = 0, x_mwd = 0;
    logic [3:0]  x_mwe = 0;

    task automatic put(input logic ifg, input logic dg, input logic mreq,
                       input logic ifv, input logic dv, input logic [31:0] rd,
                       input logic er);
        vec_t v;
        v.ifr = b_ifr; v.ifa = b_ifa; v.dr = b_dr; v.dwe = b_dwe;
        v.da = b_da; v.dwd = b_dwd; v.ack = b_ack; v.mrd = b_mrd;
        v.e_ifg = ifg; v.e_dg = dg; v.e_mreq = mreq; v.e_ifv = ifv; v.e_dv = dv;
        v.e_rd = rd; v.e_err = er;
        v.e_maddr = x_maddr; v.e_mwe = x_mwe; v.e_mwd = x_mwd;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%s]: got %h, expected %h", nm, tag, act, exp);
        end
    endtask

    task automatic chk_idle_zero();
        chk("if_gnt", 32'(if_gnt), 0);       chk("d_gnt", 32'(d_gnt), 0);
        chk("if_rvalid", 32'(if_rvalid), 0); chk("if_rdata", if_rdata, 0);
        chk("if_err", 32'(if_err), 0);       chk("d_rvalid", 32'(d_rvalid), 0);
        chk("d_rdata", d_rdata, 0);          chk("d_err", 32'(d_err), 0);
        chk("mem_req", 32'(mem_req), 0);     chk("mem_addr", mem_addr, 0);
        chk("mem_we", 32'(mem_we), 0);       chk("mem_wdata", mem_wdata, 0);
        chk("busy", 32'(busy), 0);
    endtask

    initial begin
        int unsigned k;
        reset = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; mem_ack = 0; mem_rdata = 0;
        @(negedge clk); @(negedge clk);
        reset = 0;
        #1 tag = "after reset"; n_vec++; chk_idle_zero();
        @(negedge clk);

        // ---------------- table ----------------
        put(0,0,0,0,0,0,0);
        // single fetch, ack two cycles after grant
        b_ifr = 1; b_ifa = 32'h100;              put(1,0,0,0,0,0,0);
        b_ifr = 0; x_maddr = 32'h100;            put(0,0,1,0,0,0,0);
        b_ack = 1; b_mrd = 32'h13;               put(0,0,1,0,0,0,0);
        b_ack = 0;                               put(0,0,0,1,0,32'h13,0);
        // collision: data wins, fetch granted in the cycle of the data response
        b_ifr = 1; b_ifa = 32'h104; b_dr = 1; b_da = 32'h2000; put(0,1,0,0,0,0,0);
        b_dr = 0; x_maddr = 32'h2000;            put(0,0,1,0,0,0,0);
        b_ack = 1; b_mrd = 32'hDEADBEEF;         put(0,0,1,0,0,0,0);
        b_ack = 0;                               put(1,0,0,0,1,32'hDEADBEEF,0);
        b_ifr = 0; x_maddr = 32'h104;            put(0,0,1,0,0,0,0);
        b_ack = 1; b_mrd = 32'h11111111;         put(0,0,1,0,0,0,0);
        b_ack = 0;                               put(0,0,0,1,0,32'h11111111,0);
        // starvation: four data grants, then fetch
        b_ifr = 1; b_ifa = 32'h108; b_dr = 1; b_da = 32'h3000; put(0,1,0,0,0,0,0);
        x_maddr = 32'h3000;
        for (int i = 1; i <= 4; i++) begin
            b_ack = 1; b_mrd = 32'hA0 + 32'(i);  put(0,0,1,0,0,0,0);
            b_ack = 0; put(i == 4, i != 4, 0, 0, 1, 32'hA0 + 32'(i), 0);
        end
        b_ifr = 0; x_maddr = 32'h108; b_ack = 1; b_mrd = 32'h108F; put(0,0,1,0,0,0,0);
        // streak was cleared: a new collision goes to data again
        b_ack = 0; b_ifr = 1; b_ifa = 32'h10C;   put(0,1,0,1,0,32'h108F,0);
        b_dr = 0; x_maddr = 32'h3000; b_ack = 1; b_mrd = 32'h55; put(0,0,1,0,0,0,0);
        b_ack = 0;                               put(1,0,0,0,1,32'h55,0);
        b_ifr = 0; x_maddr = 32'h10C; b_ack = 1; b_mrd = 32'h66; put(0,0,1,0,0,0,0);
        b_ack = 0;                               put(0,0,0,1,0,32'h66,0);
        // byte-strobed write; inputs scrambled after grant
        b_dr = 1; b_dwe = 4'b0011; b_da = 32'h3004; b_dwd = 32'hAABBCCDD; put(0,1,0,0,0,0,0);
        b_dr = 0; b_dwe = 4'hF; b_da = 0; b_dwd = 0;
        x_maddr = 32'h3004; x_mwe = 4'b0011; x_mwd = 32'hAABBCCDD;
        put(0,0,1,0,0,0,0); put(0,0,1,0,0,0,0);
        b_ack = 1; b_mrd = 32'h12345678;         put(0,0,1,0,0,0,0);
        b_ack = 0;                               put(0,0,0,0,1,0,0);
        // timeout: eight ACCESS cycles, then error; late ack ignored
        b_dr = 1; b_dwe = 0; b_da = 32'h4000;    put(0,1,0,0,0,0,0);
        b_dr = 0; x_maddr = 32'h4000; x_mwe = 0; x_mwd = 0;
        for (int i = 0; i < 8; i++)              put(0,0,1,0,0,0,0);
        put(0,0,0,0,1,0,1);
        b_ack = 1; b_mrd = 32'h77;               put(0,0,0,0,0,0,0);
        b_ack = 0;                               put(0,0,0,0,0,0,0);

        foreach (vq[i]) begin
            if_req = vq[i].ifr; if_addr = vq[i].ifa; d_req = vq[i].dr;
            d_we = vq[i].dwe; d_addr = vq[i].da; d_wdata = vq[i].dwd;
            mem_ack = vq[i].ack; mem_rdata = vq[i].mrd;
            #1;
            tag = $sformatf("vec %0d", i);
            n_vec++;
            chk("if_gnt", 32'(if_gnt), 32'(vq[i].e_ifg));
            chk("d_gnt", 32'(d_gnt), 32'(vq[i].e_dg));
            chk("mem_req", 32'(mem_req), 32'(vq[i].e_mreq));
            chk("busy", 32'(busy), 32'(vq[i].e_mreq));
            chk("if_rvalid", 32'(if_rvalid), 32'(vq[i].e_ifv));
            chk("d_rvalid", 32'(d_rvalid), 32'(vq[i].e_dv));
            if (vq[i].e_mreq) begin
                chk("mem_addr", mem_addr, vq[i].e_maddr);
                chk("mem_we", 32'(mem_we), 32'(vq[i].e_mwe));
                chk("mem_wdata", mem_wdata, vq[i].e_mwd);
            end
            if (vq[i].e_ifv) begin
                chk("if_rdata", if_rdata, vq[i].e_rd);
                chk("if_err", 32'(if_err), 32'(vq[i].e_err));
            end
            if (vq[i].e_dv) begin
                chk("d_rdata", d_rdata, vq[i].e_rd);
                chk("d_err", 32'(d_err), 32'(vq[i].e_err));
            end
            @(negedge clk);
        end
        if_req = 0; d_req = 0; mem_ack = 0; d_we = 0;

        // ---------------- reset in the middle of an access ----------------
        if_req = 1; if_addr = 32'h200;
        #1 tag = "rst grant"; n_vec++; chk("if_gnt", 32'(if_gnt), 1);
        @(negedge clk); if_req = 0;
        #1 tag = "rst access"; n_vec++; chk("mem_req", 32'(mem_req), 1);
        @(negedge clk); reset = 1; mem_ack = 1; mem_rdata = 32'h99;
        @(negedge clk); reset = 0; mem_ack = 0;
        #1 tag = "rst after"; n_vec++; chk_idle_zero();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); mem_ack = (i == 0);
            #1 tag = $sformatf("rst quiet %0d", i); n_vec++;
            chk("if_rvalid", 32'(if_rvalid), 0); chk("d_rvalid", 32'(d_rvalid), 0);
            chk("mem_req", 32'(mem_req), 0);
        end
        @(negedge clk); mem_ack = 0; if_req = 1; if_addr = 32'h204;
        #1 tag = "post-rst grant"; n_vec++; chk("if_gnt", 32'(if_gnt), 1);
        @(negedge clk); if_req = 0; mem_ack = 1; mem_rdata = 32'h2222;
        #1 tag = "post-rst access"; n_vec++;
        chk("mem_req", 32'(mem_req), 1); chk("mem_addr", mem_addr, 32'h204);
        @(negedge clk); mem_ack = 0;
        #1 tag = "post-rst resp"; n_vec++;
        chk("if_rvalid", 32'(if_rvalid), 1); chk("if_rdata", if_rdata, 32'h2222);
        chk("if_err", 32'(if_err), 0);

        // ---------------- write with a random ack delay ----------------
        k = $urandom_range(1, 6);
        @(negedge clk);
        d_req = 1; d_we = 4'b1100; d_addr = 32'h5008; d_wdata = 32'h0BADF00D;
        #1 tag = "rand grant"; n_vec++; chk("d_gnt", 32'(d_gnt), 1);
        @(negedge clk); d_req = 0; d_we = 0;
        for (int unsigned c = 1; c <= k; c++) begin
            mem_ack = (c == k); mem_rdata = 32'hFFFF0000;
            #1 tag = $sformatf("rand wait %0d/%0d", c, k); n_vec++;
            chk("mem_req", 32'(mem_req), 1); chk("mem_we", 32'(mem_we), 32'hC);
            chk("mem_wdata", mem_wdata, 32'h0BADF00D);
            chk("d_rvalid", 32'(d_rvalid), 0);
            @(negedge clk);
        end
        mem_ack = 0;
        #1 tag = "rand resp"; n_vec++;
        chk("d_rvalid", 32'(d_rvalid), 1); chk("d_rdata", d_rdata, 0);
        chk("d_err", 32'(d_err), 0); chk("mem_req", 32'(mem_req), 0);
        @(negedge clk);
        #1 tag = "rand after"; n_vec++; chk("d_rvalid", 32'(d_rvalid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
